mem_bank_port_arbiter: RTL and testbench
========================================

// Module: mem_bank_port_arbiter
// PURPOSE
// Shares one memory bank between NumPorts mem-stream requesters (req/gnt/rvalid protocol used by
// the axi_to_mem family). Round-robin arbitration with lock-until-grant. A route FIFO steers each
// in-order mem_rvalid_i back to the port that issued the request. A credit counter bounds the
// number of outstanding requests. Sits between per-port axi_to_mem instances and a single SRAM bank.
// PARAMETERS
// NumPorts        2   number of requester ports, >=2
// AddrWidth       32  byte address width
// DataWidth       32  bank data width, multiple of 8
// MaxOutstanding  2   max granted-but-unanswered requests (>= bank read latency + 1), >=1
// PORTS
// clk_i          in   1                      clock, rising edge
// rst_i          in   1                      synchronous reset, active-high
// busy_o         out  1                      any port requesting or any request outstanding
// port_req_i     in   NumPorts               per-port request valid
// port_gnt_o     out  NumPorts               per-port grant (one-hot or zero)
// port_addr_i    in   NumPorts x AddrWidth   per-port byte address
// port_wdata_i   in   NumPorts x DataWidth   per-port write data
// port_strb_i    in   NumPorts x DataWidth/8 per-port byte strobe
// port_we_i      in   NumPorts               per-port write enable
// port_rvalid_o  out  NumPorts               per-port response valid (one-hot or zero)
// port_rdata_o   out  DataWidth              response data, broadcast to all ports
// mem_req_o      out  1                      bank request valid
// mem_gnt_i      in   1                      bank grant
// mem_addr_o / mem_wdata_o / mem_strb_o / mem_we_o   out   payload of the selected port
// mem_rvalid_i   in   1                      bank response valid, one per granted request, in order
// mem_rdata_i    in   DataWidth              bank read data
// BEHAVIOUR
// - State: rr_ptr (clog2(NumPorts), min 1 bit), lock_q + lock_idx_q, credit count
//   (clog2(MaxOutstanding+1) bits), route FIFO (MaxOutstanding x idx).
// - Reset (rst_i=1 at edge): rr_ptr=0, lock_q=0, count=0, FIFO empty. With port_req_i=0 this gives
//   mem_req_o=0, port_gnt_o=0, port_rvalid_o=0, busy_o=0.
// - Select: if lock_q, sel=lock_idx_q; else sel = first requesting index at or after rr_ptr, with
//   wrap-around.
// - mem_req_o = |port_req_i && count<MaxOutstanding. A same-cycle rvalid does NOT free credit.
//   No combinational path exists from mem_rvalid_i to mem_req_o.
// - mem_* payload = port payload[sel], combinational, zero added latency.
// - port_gnt_o[sel] = mem_req_o & mem_gnt_i.
// - Lock: mem_req_o=1 and mem_gnt_i=0 -> lock_q<=1, lock_idx_q<=sel. Cleared on handshake.
//   Requesters hold req and payload stable until gnt. The arbiter never switches sel while locked.
// - Handshake (mem_req_o & mem_gnt_i): push sel into FIFO, rr_ptr<=(sel+1)%NumPorts, count+1.
// - Response: mem_rvalid_i & !empty -> port_rvalid_o[head]=1 (same cycle), pop, count-1.
//   port_rdata_o = mem_rdata_i always.
// - Push and pop in the same cycle: count unchanged. FIFO never overflows because of the credit gate.
// - mem_rvalid_i while FIFO empty: protocol error. Ignore it: no port_rvalid_o, count stays 0.
//   Flag it with a simulation assertion.
// - count==MaxOutstanding: mem_req_o=0 and lock is unaffected. Resumes the cycle after a pop.
// - Reset mid-operation: outstanding tracking is discarded. Later stray rvalids follow the
//   empty-FIFO rule.
// - busy_o = |port_req_i || count!=0.
// - Assertions: port_gnt_o and port_rvalid_o are $onehot0; a locked port's req does not drop
//   before gnt.
// TESTING
// 1 Reset: rst_i=1 for 2 cycles with ports idle -> all outputs 0, count=0.
// 2 RR fairness: NumPorts=3, all ports request continuously, mem_gnt_i=1, 1-cycle rvalid ->
//   grant order 0,1,2,0,1,2; each port_rvalid_o follows its grant by 1 cycle.
// 3 Lock: port1 requests with mem_gnt_i=0 for 3 cycles, port0 raises req in cycle 2 ->
//   sel stays 1 and mem_addr_o = port_addr_i[1] until gnt; port0 is granted next.
// 4 Credit: MaxOutstanding=2, rvalid withheld -> 2 grants then mem_req_o=0;
//   1 rvalid -> mem_req_o=1 the next cycle.
// 5 Routing: grants to ports 2,0,2 with rdata 0xA,0xB,0xC on 3 later rvalids ->
//   port_rvalid_o = 100,001,100 with matching data.
// 6 Stray/reset: reset with 2 outstanding, then 2 rvalids -> no port_rvalid_o, count=0,
//   assertion fires.

Source files
------------

// File: rtl/mem_bank_port_arbiter.sv
// Shares one SRAM bank between several req/gnt/rvalid requesters.
// Round-robin arbitration holds its choice until the bank grants it. A route FIFO
// remembers which port each granted request came from, so in-order bank responses
// are steered back to their issuer. The FIFO occupancy doubles as the credit count
// that bounds the number of outstanding requests.

module mem_bank_port_arbiter #(
   parameter int NumPorts       = 2,
   parameter int AddrWidth      = 32,
   parameter int DataWidth      = 32,
   parameter int MaxOutstanding = 2
) (
   input  logic                                     clk_i,
   input  logic                                     rst_i,
   output logic                                     busy_o,
   input  logic [NumPorts-1:0]                      port_req_i,
   output logic [NumPorts-1:0]                      port_gnt_o,
   input  logic [NumPorts-1:0][AddrWidth-1:0]       port_addr_i,
   input  logic [NumPorts-1:0][DataWidth-1:0]       port_wdata_i,
   input  logic [NumPorts-1:0][DataWidth/8-1:0]     port_strb_i,
   input  logic [NumPorts-1:0]                      port_we_i,
   output logic [NumPorts-1:0]                      port_rvalid_o,
   output logic [DataWidth-1:0]                     port_rdata_o,
   output logic                                     mem_req_o,
   input  logic                                     mem_gnt_i,
   output logic [AddrWidth-1:0]                     mem_addr_o,
   output logic [DataWidth-1:0]                     mem_wdata_o,
   output logic [DataWidth/8-1:0]                   mem_strb_o,
   output logic                                     mem_we_o,
   input  logic                                     mem_rvalid_i,
   input  logic [DataWidth-1:0]                     mem_rdata_i
);

   localparam int IdxWidth = (NumPorts > 1) ? $clog2(NumPorts) : 1;
   localparam int CntWidth = $clog2(MaxOutstanding + 1);
   localparam int PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

   logic [IdxWidth-1:0] rr_ptr_r;
   logic                lock_r;
   logic [IdxWidth-1:0] lock_idx_r;
   logic [CntWidth-1:0] count_r;
   logic [IdxWidth-1:0] route_fifo_r [MaxOutstanding];
   logic [PtrWidth-1:0] wr_ptr_r;
   logic [PtrWidth-1:0] rd_ptr_r;

   logic [IdxWidth-1:0] rr_sel_s;
   logic [IdxWidth-1:0] sel_s;
   logic [IdxWidth-1:0] head_idx_s;
   logic                any_req_s;
   logic                credit_ok_s;
   logic                mem_req_s;
   logic                handshake_s;
   logic                fifo_empty_s;
   logic                pop_s;
   logic [NumPorts-1:0] port_gnt_s;
   logic [NumPorts-1:0] port_rvalid_s;

   // Port index after idx, wrapping at NumPorts.
   function automatic logic [IdxWidth-1:0] next_idx(input logic [IdxWidth-1:0] idx);
      if (idx == IdxWidth'(NumPorts - 1)) begin
         return {IdxWidth{1'b0}};
      end else begin
         return idx + IdxWidth'(1);
      end
   endfunction

   // FIFO slot after ptr, wrapping at MaxOutstanding.
   function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] ptr);
      if (ptr == PtrWidth'(MaxOutstanding - 1)) begin
         return {PtrWidth{1'b0}};
      end else begin
         return ptr + PtrWidth'(1);
      end
   endfunction

   // Credit is judged on the registered count only, so a response arriving this
   // cycle cannot re-open the request gate combinationally.
   assign any_req_s    = |port_req_i;
   assign fifo_empty_s = (count_r == CntWidth'(0));
   assign credit_ok_s  = (count_r < CntWidth'(MaxOutstanding));
   assign mem_req_s    = any_req_s & credit_ok_s;
   assign handshake_s  = mem_req_s & mem_gnt_i;
   assign pop_s        = mem_rvalid_i & ~fifo_empty_s;
   assign head_idx_s   = route_fifo_r[rd_ptr_r];

   // First requesting port at or after the round-robin pointer, with wrap-around.
   always_comb begin
      logic                found;
      logic [IdxWidth-1:0] cand;
      rr_sel_s = rr_ptr_r;
      found    = 1'b0;
      cand     = {IdxWidth{1'b0}};
      for (int i = 0; i < NumPorts; i++) begin
         cand = IdxWidth'((int'(rr_ptr_r) + i) % NumPorts);
         if (!found && port_req_i[cand]) begin
            rr_sel_s = cand;
            found    = 1'b1;
         end else begin
            found    = found;
         end
      end
   end

   // A stalled request keeps its port until the bank accepts it.
   always_comb begin
      sel_s = rr_sel_s;
      if (lock_r) begin
         sel_s = lock_idx_r;
      end else begin
         sel_s = rr_sel_s;
      end
   end

   // One-hot grant to the selected port and response strobe to the FIFO head.
   always_comb begin
      port_gnt_s    = {NumPorts{1'b0}};
      port_rvalid_s = {NumPorts{1'b0}};
      for (int i = 0; i < NumPorts; i++) begin
         port_gnt_s[i]    = handshake_s & (sel_s == IdxWidth'(i));
         port_rvalid_s[i] = pop_s & (head_idx_s == IdxWidth'(i));
      end
   end

   assign mem_req_o     = mem_req_s;
   assign mem_addr_o    = port_addr_i[sel_s];
   assign mem_wdata_o   = port_wdata_i[sel_s];
   assign mem_strb_o    = port_strb_i[sel_s];
   assign mem_we_o      = port_we_i[sel_s];
   assign port_gnt_o    = port_gnt_s;
   assign port_rvalid_o = port_rvalid_s;
   assign port_rdata_o  = mem_rdata_i;
   assign busy_o        = any_req_s | ~fifo_empty_s;

   // Round-robin pointer advances past each port that completes a handshake.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr_r <= {IdxWidth{1'b0}};
      end else if (handshake_s) begin
         rr_ptr_r <= next_idx(sel_s);
      end else begin
         rr_ptr_r <= rr_ptr_r;
      end
   end

   // Lock is taken when the bank stalls a request and released on its grant.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lock_r     <= 1'b0;
         lock_idx_r <= {IdxWidth{1'b0}};
      end else if (handshake_s) begin
         lock_r     <= 1'b0;
         lock_idx_r <= lock_idx_r;
      end else if (mem_req_s && !mem_gnt_i) begin
         lock_r     <= 1'b1;
         lock_idx_r <= sel_s;
      end else begin
         lock_r     <= lock_r;
         lock_idx_r <= lock_idx_r;
      end
   end

   // Route FIFO: push the issuing port on handshake, pop on each matched response.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_r <= {PtrWidth{1'b0}};
         rd_ptr_r <= {PtrWidth{1'b0}};
         for (int i = 0; i < MaxOutstanding; i++) begin
            route_fifo_r[i] <= {IdxWidth{1'b0}};
         end
      end else begin
         if (handshake_s) begin
            route_fifo_r[wr_ptr_r] <= sel_s;
            wr_ptr_r               <= next_ptr(wr_ptr_r);
         end else begin
            wr_ptr_r               <= wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= next_ptr(rd_ptr_r);
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
      end
   end

   // Outstanding count; a simultaneous push and pop leaves it unchanged.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_r <= CntWidth'(0);
      end else begin
         case ({handshake_s, pop_s})
            2'b10:   count_r <= count_r + CntWidth'(1);
            2'b01:   count_r <= count_r - CntWidth'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   mem_bank_port_arbiter_checker #(
      .NumPorts (NumPorts),
      .IdxWidth (IdxWidth)
   ) u_checker (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .port_req    (port_req_i),
      .port_gnt    (port_gnt_s),
      .port_rvalid (port_rvalid_s),
      .lock        (lock_r),
      .lock_idx    (lock_idx_r),
      .mem_rvalid  (mem_rvalid_i),
      .fifo_empty  (fifo_empty_s)
   );

endmodule

// Simulation-only protocol checks for the arbiter.
module mem_bank_port_arbiter_checker #(
   parameter int NumPorts = 2,
   parameter int IdxWidth = 1
) (
   input logic                clk_i,
   input logic                rst_i,
   input logic [NumPorts-1:0] port_req,
   input logic [NumPorts-1:0] port_gnt,
   input logic [NumPorts-1:0] port_rvalid,
   input logic                lock,
   input logic [IdxWidth-1:0] lock_idx,
   input logic                mem_rvalid,
   input logic                fifo_empty
);

   // Output encodings, requester hold rule and stray bank responses.
   always @(posedge clk_i) begin
      if (!rst_i) begin
         assert ($onehot0(port_gnt)) else $error("port_gnt_o is not one-hot or zero");
         assert ($onehot0(port_rvalid)) else $error("port_rvalid_o is not one-hot or zero");
         if (lock) begin
            assert (port_req[lock_idx]) else $error("locked port dropped its request before grant");
         end
         assert (!(mem_rvalid && fifo_empty)) else $warning("mem_rvalid_i with no outstanding request, ignored");
      end
   end

endmodule

// File: tb/tb_mem_bank_port_arbiter.sv
// Scoreboard bench for mem_bank_port_arbiter: directed scenarios plus random traffic,
// predicted by a queue-based reference model and checked by an independent monitor.

module tb_mem_bank_port_arbiter;

   localparam int NP   = 3;
   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int SW   = DW / 8;
   localparam int MAXO = 2;

   logic                   clk_i = 1'b0;
   logic                   rst_i;
   logic                   busy_o;
   logic [NP-1:0]          port_req_i;
   logic [NP-1:0]          port_gnt_o;
   logic [NP-1:0][AW-1:0]  port_addr_i;
   logic [NP-1:0][DW-1:0]  port_wdata_i;
   logic [NP-1:0][SW-1:0]  port_strb_i;
   logic [NP-1:0]          port_we_i;
   logic [NP-1:0]          port_rvalid_o;
   logic [DW-1:0]          port_rdata_o;
   logic                   mem_req_o;
   logic                   mem_gnt_i;
   logic [AW-1:0]          mem_addr_o;
   logic [DW-1:0]          mem_wdata_o;
   logic [SW-1:0]          mem_strb_o;
   logic                   mem_we_o;
   logic                   mem_rvalid_i;
   logic [DW-1:0]          mem_rdata_i;

   mem_bank_port_arbiter #(
      .NumPorts(NP), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MAXO)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .busy_o(busy_o),
      .port_req_i(port_req_i), .port_gnt_o(port_gnt_o), .port_addr_i(port_addr_i),
      .port_wdata_i(port_wdata_i), .port_strb_i(port_strb_i), .port_we_i(port_we_i),
      .port_rvalid_o(port_rvalid_o), .port_rdata_o(port_rdata_o),
      .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_strb_o(mem_strb_o), .mem_we_o(mem_we_o),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct { int port; logic [AW-1:0] addr; logic we; logic [DW-1:0] wdata; logic [SW-1:0] strb; } gnt_t;
   typedef struct { int port; logic [DW-1:0] rdata; } resp_t;
   typedef struct { bit req; bit busy; logic [AW-1:0] addr; } cyc_t;

   // Scoreboard queues (filled by the model, drained by the monitor).
   gnt_t  exp_gnt[$];
   resp_t exp_resp[$];
   cyc_t  exp_cyc[$];

   // Reference model state: requesters, pointer, lock owner, outstanding requests.
   bit            pend  [NP];
   logic [AW-1:0] paddr [NP];
   logic [DW-1:0] pwdata[NP];
   logic [SW-1:0] pstrb [NP];
   bit            pwe   [NP];
   int            rr_m;
   int            lock_m;
   resp_t         outq[$];
   logic [DW-1:0] rdata_seq[$];
   bit            known;

   // Monitor logs for directed-sequence checks.
   logic [NP-1:0] gnt_log[$];
   logic [NP-1:0] rv_log[$];
   logic [DW-1:0] rd_log[$];
   bit            req_log[$];

   int checks;
   int errors;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit any_pend();
      bit a = 1'b0;
      for (int p = 0; p < NP; p++) a |= pend[p];
      return a;
   endfunction

   task automatic raise(input int p);
      pend[p]   = 1'b1;
      paddr[p]  = $urandom;
      pwdata[p] = $urandom;
      pstrb[p]  = SW'($urandom);
      pwe[p]    = $urandom_range(0, 1) == 1;
   endtask

   // Predict this cycle's outputs from the arbitration rules, then advance the model.
   task automatic model_eval();
      int    cnt = outq.size();
      bit    any = |port_req_i;
      bit    mreq = any && (cnt < MAXO);
      int    sel = 0;
      bit    found = 1'b0;
      bit    hs, pop;
      resp_t r;
      if (lock_m >= 0) begin
         sel = lock_m;
      end else begin
         for (int i = 0; i < NP; i++) begin
            if (!found && port_req_i[(rr_m + i) % NP]) begin
               sel = (rr_m + i) % NP;
               found = 1'b1;
            end
         end
      end
      hs  = mreq && mem_gnt_i;
      pop = mem_rvalid_i && (cnt > 0);
      if (known) exp_cyc.push_back('{mreq, any || (cnt != 0), paddr[sel]});
      if (hs) exp_gnt.push_back('{sel, paddr[sel], pwe[sel], pwdata[sel], pstrb[sel]});
      if (rst_i) begin
         rr_m   = 0;
         lock_m = -1;
         outq.delete();
         exp_resp.delete();
         known  = 1'b1;
      end else begin
         if (pop) outq.delete(0);
         if (hs) begin
            r.port  = sel;
            r.rdata = (rdata_seq.size() > 0) ? rdata_seq.pop_front() : DW'($urandom);
            outq.push_back(r);
            exp_resp.push_back(r);
            rr_m      = (sel + 1) % NP;
            lock_m    = -1;
            pend[sel] = 1'b0;
         end else if (mreq && !mem_gnt_i) begin
            lock_m = sel;
         end
      end
   endtask

   // Drive one cycle. rv_mode: 0 no response, 1 respond if outstanding, 2 force rvalid.
   task automatic step(input bit rst, input bit gnt, input int rv_mode);
      rst_i     = rst;
      mem_gnt_i = gnt;
      for (int p = 0; p < NP; p++) begin
         port_req_i[p]   = pend[p];
         port_addr_i[p]  = paddr[p];
         port_wdata_i[p] = pwdata[p];
         port_strb_i[p]  = pstrb[p];
         port_we_i[p]    = pwe[p];
      end
      mem_rvalid_i = (rv_mode == 2) || (rv_mode == 1 && outq.size() > 0);
      mem_rdata_i  = (outq.size() > 0) ? outq[0].rdata : DW'($urandom);
      model_eval();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 0);
      step(1'b1, 1'b0, 0);
   endtask

   task automatic drain();
      int n = 0;
      while ((any_pend() || outq.size() != 0) && n < 60) begin
         step(1'b0, 1'b1, 1);
         n++;
      end
      chk("drain_done", 64'(any_pend() || outq.size() != 0), 64'd0);
   endtask

   task automatic clear_logs();
      gnt_log.delete();
      rv_log.delete();
      rd_log.delete();
      req_log.delete();
   endtask

   // Monitor: compare every presented grant/response and each cycle's request/busy.
   cyc_t  mon_c;
   gnt_t  mon_g;
   resp_t mon_r;
   always @(negedge clk_i) begin
      req_log.push_back(mem_req_o);
      if (exp_cyc.size() > 0) begin
         mon_c = exp_cyc.pop_front();
         chk("mem_req_o", 64'(mem_req_o), 64'(mon_c.req));
         chk("busy_o", 64'(busy_o), 64'(mon_c.busy));
         if (mon_c.req) chk("mem_addr_o", 64'(mem_addr_o), 64'(mon_c.addr));
      end
      if (port_gnt_o != '0) begin
         gnt_log.push_back(port_gnt_o);
         if (exp_gnt.size() == 0) begin
            chk("unexpected_gnt", 64'(port_gnt_o), 64'd0);
         end else begin
            mon_g = exp_gnt.pop_front();
            chk("gnt_port", 64'(port_gnt_o), 64'd1 << mon_g.port);
            chk("gnt_addr", 64'(mem_addr_o), 64'(mon_g.addr));
            chk("gnt_we", 64'(mem_we_o), 64'(mon_g.we));
            chk("gnt_wdata", 64'(mem_wdata_o), 64'(mon_g.wdata));
            chk("gnt_strb", 64'(mem_strb_o), 64'(mon_g.strb));
         end
      end
      if (port_rvalid_o != '0) begin
         rv_log.push_back(port_rvalid_o);
         rd_log.push_back(port_rdata_o);
         if (exp_resp.size() == 0) begin
            chk("unexpected_rvalid", 64'(port_rvalid_o), 64'd0);
         end else begin
            mon_r = exp_resp.pop_front();
            chk("rvalid_port", 64'(port_rvalid_o), 64'd1 << mon_r.port);
            chk("rvalid_data", 64'(port_rdata_o), 64'(mon_r.rdata));
         end
      end
   end

   logic [NP-1:0] rr_exp [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
   bit            cr_exp [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
   logic [NP-1:0] rt_exp [3] = '{3'b100, 3'b001, 3'b100};
   logic [DW-1:0] rd_exp [3] = '{32'h0000_000A, 32'h0000_000B, 32'h0000_000C};

   initial begin
      checks = 0;
      errors = 0;
      rr_m   = 0;
      lock_m = -1;
      known  = 1'b0;
      for (int p = 0; p < NP; p++) begin
         pend[p] = 1'b0; paddr[p] = '0; pwdata[p] = '0; pstrb[p] = '0; pwe[p] = 1'b0;
      end
      rst_i = 1'b1; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
      port_req_i = '0; port_addr_i = '0; port_wdata_i = '0; port_strb_i = '0; port_we_i = '0;
      @(posedge clk_i);
      #1;

      // Reset with idle ports, then one idle cycle.
      do_reset();
      step(1'b0, 1'b0, 0);
      chk("reset_gnt", 64'(port_gnt_o), 64'd0);
      chk("reset_rvalid", 64'(port_rvalid_o), 64'd0);

      // Round-robin fairness with continuous requests and 1-cycle responses.
      clear_logs();
      for (int c = 0; c < 6; c++) begin
         for (int p = 0; p < NP; p++) if (!pend[p]) raise(p);
         step(1'b0, 1'b1, 1);
      end
      drain();
      chk("rr_len", 64'(gnt_log.size() >= 6), 64'd1);
      for (int i = 0; i < 6; i++) begin
         chk("rr_order", 64'((i < gnt_log.size()) ? gnt_log[i] : '0), 64'(rr_exp[i]));
         chk("rr_route", 64'((i < rv_log.size()) ? rv_log[i] : '0), 64'(rr_exp[i]));
      end

      // Lock: port1 stalls for 3 cycles, port0 joins in the second.
      do_reset();
      clear_logs();
      raise(1);
      step(1'b0, 1'b0, 0);
      raise(0);
      step(1'b0, 1'b0, 0);
      step(1'b0, 1'b0, 0);
      step(1'b0, 1'b1, 0);
      step(1'b0, 1'b1, 1);
      drain();
      chk("lock_len", 64'(gnt_log.size()), 64'd2);
      chk("lock_first", 64'((gnt_log.size() > 0) ? gnt_log[0] : '0), 64'd2);
      chk("lock_second", 64'((gnt_log.size() > 1) ? gnt_log[1] : '0), 64'd1);

      // Credit limit: two grants, gate closes, one response reopens it a cycle later.
      do_reset();
      for (int p = 0; p < NP; p++) raise(p);
      clear_logs();
      for (int c = 0; c < 4; c++) step(1'b0, 1'b1, 0);
      step(1'b0, 1'b1, 1);
      step(1'b0, 1'b1, 0);
      for (int i = 0; i < 6; i++) begin
         chk("credit_req", 64'((i < req_log.size()) ? req_log[i] : 1'b0), 64'(cr_exp[i]));
      end
      drain();

      // Routing: grants to 2,0,2 answered with 0xA,0xB,0xC.
      do_reset();
      clear_logs();
      rdata_seq.push_back(32'h0000_000A);
      rdata_seq.push_back(32'h0000_000B);
      rdata_seq.push_back(32'h0000_000C);
      raise(2);
      step(1'b0, 1'b1, 0);
      raise(0);
      step(1'b0, 1'b1, 0);
      raise(2);
      step(1'b0, 1'b1, 0);
      step(1'b0, 1'b1, 1);
      step(1'b0, 1'b1, 1);
      step(1'b0, 1'b1, 1);
      chk("route_len", 64'(rv_log.size()), 64'd3);
      for (int i = 0; i < 3; i++) begin
         chk("route_port", 64'((i < rv_log.size()) ? rv_log[i] : '0), 64'(rt_exp[i]));
         chk("route_data", 64'((i < rd_log.size()) ? rd_log[i] : '0), 64'(rd_exp[i]));
      end
      drain();

      // Reset with two outstanding, then two stray responses.
      do_reset();
      raise(0);
      raise(1);
      step(1'b0, 1'b1, 0);
      step(1'b0, 1'b1, 0);
      step(1'b1, 1'b0, 0);
      clear_logs();
      step(1'b0, 1'b0, 2);
      step(1'b0, 1'b0, 2);
      step(1'b0, 1'b0, 0);
      chk("stray_rvalid", 64'(rv_log.size()), 64'd0);
      chk("stray_busy", 64'(busy_o), 64'd0);

      // Random traffic with random bank stalls and response latency.
      for (int c = 0; c < 1500; c++) begin
         for (int p = 0; p < NP; p++) begin
            if (!pend[p] && $urandom_range(0, 99) < 40) raise(p);
         end
         step(1'b0, $urandom_range(0, 3) != 0, ($urandom_range(0, 2) != 0) ? 1 : 0);
      end
      drain();
      step(1'b0, 1'b0, 0);

      chk("left_gnt", 64'(exp_gnt.size()), 64'd0);
      chk("left_resp", 64'(exp_resp.size()), 64'd0);
      chk("left_cyc", 64'(exp_cyc.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
